// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
//
// n-bit universal shift register with hold, shift right, shift left and
// parallel load. A shift counter tracks how many shifts have happened since
// the last load (or since the last completed word). word_done pulses for
// exactly one cycle when the n-th shift of a word lands.
//
// Optional feature (compile-time macro):
//   USR_ROTATE_EN : when defined, rot=1 in a shift mode recirculates the
//                   outgoing bit instead of taking SI_R / SI_L. When undefined,
//                   rot is accepted but has no effect.
//
// Parameters:
//   n         register width in bits (n >= 2)
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset (Q, bit_cnt, word_done -> 0)
//   en        clock enable; 0 freezes all state (word_done drops to 0)
//   mode      00 hold, 01 shift right, 10 shift left, 11 parallel load
//   rot       rotate request for shift modes (see USR_ROTATE_EN)
//   SI_R      serial in, enters bit n-1 on a right shift
//   SI_L      serial in, enters bit 0 on a left shift
//   D         parallel load data
//   Q         register contents
//   SO_R      right serial out (Q[0])
//   SO_L      left serial out (Q[n-1])
//   bit_cnt   shifts completed in the current word, 0..n-1
//   word_done one-cycle pulse, aligned with Q, after the n-th shift of a word
// -----------------------------------------------------------------------------
module universal_shift_register #(
    parameter int n = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic [1:0]                mode,
    input  logic                      rot,
    input  logic                      SI_R,
    input  logic                      SI_L,
    input  logic [n-1:0]              D,
    output logic [n-1:0]              Q,
    output logic                      SO_R,
    output logic                      SO_L,
    output logic [$clog2(n+1)-1:0]    bit_cnt,
    output logic                      word_done
);

    localparam int CW = $clog2(n+1);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic in_r;
    logic in_l;
    logic shift;
    logic last_bit;

    // Serial input selection; rotation feeds the bit falling off the far end
    // back in, so the word recirculates unchanged after n shifts.
    always_comb begin
        in_r = SI_R;
        in_l = SI_L;
`ifdef USR_ROTATE_EN
        if (rot) begin
            in_r = Q[0];
            in_l = Q[n-1];
        end
`endif
    end

`ifndef USR_ROTATE_EN
    // rot is part of the interface in every build but only consumed when
    // rotation is compiled in.
    logic rot_unused;
    assign rot_unused = rot;
`endif

    assign shift    = en && ((mode == MODE_SHR) || (mode == MODE_SHL));
    assign last_bit = (bit_cnt == CW'(n-1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Q         <= '0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
        end else begin
            // word_done is a single-edge pulse: cleared on every edge unless
            // this edge completes a word.
            word_done <= 1'b0;
            if (en) begin
                case (mode)
                    MODE_SHR:  Q <= {in_r, Q[n-1:1]};
                    MODE_SHL:  Q <= {Q[n-2:0], in_l};
                    MODE_LOAD: Q <= D;
                    default:   Q <= Q;
                endcase

                if (mode == MODE_LOAD) begin
                    bit_cnt <= '0;
                end else if (shift) begin
                    // Direction does not matter for counting; the n-th
                    // shift wraps the count and flags the completed word.
                    if (last_bit) begin
                        bit_cnt   <= '0;
                        word_done <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
            end
        end
    end

    assign SO_R = Q[0];
    assign SO_L = Q[n-1];

    // MODE_HOLD is the implicit default of the case above.
    logic [1:0] mode_hold_unused;
    assign mode_hold_unused = MODE_HOLD;

endmodule
